debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 129 ++++++++++++
 tb/tb_debounce_bank.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent input debouncers.
//   Each channel runs din through a SYNC_STAGES-deep synchronizer, then
//   accepts a new level only after STABLE_CYCLES consecutive samples that
//   differ from the current output. Channels with MODE[i]=1 drop their
//   output as soon as a low sample arrives (fast release).
// Ports:
//   CLK         single clock
//   rst_n       async active-low reset, release synchronous to CLK
//   din         [N_CH-1:0] raw asynchronous inputs
//   dout        [N_CH-1:0] debounced levels
//   rise/fall   [N_CH-1:0] one-cycle pulses on dout 0->1 / 1->0
//   any_change  OR of all rise/fall, same cycle

// One debounced channel.
module debounce_lane #(
  parameter int   STABLE_CYCLES = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter logic FAST_REL      = 1'b0,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic chg_nxt
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (s == dout_q) begin
      cnt_d = '0;
    end else if (FAST_REL && !s) begin
      dout_d = 1'b0;
      cnt_d  = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // Last stable sample: take the new level and start over.
      dout_d = s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      dout_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  // Next-cycle change flag, registered by the bank into any_change.
  assign chg_nxt = dout_d ^ dout_q;
endmodule

module debounce_bank #(
  parameter int              N_CH          = 4,
  parameter int              STABLE_CYCLES = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [N_CH-1:0] MODE          = '0,
  parameter logic [N_CH-1:0] RESET_VAL     = '0
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);
  logic [N_CH-1:0] chg_nxt;
  logic            any_change_q, any_change_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    debounce_lane #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .FAST_REL      (MODE[i]),
      .RST_VAL       (RESET_VAL[i])
    ) u_lane (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .din     (din[i]),
      .dout    (dout[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .chg_nxt (chg_nxt[i])
    );
  end

  always_comb begin
    any_change_d = |chg_nxt;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) any_change_q <= 1'b0;
    else        any_change_q <= any_change_d;
  end

  assign any_change = any_change_q;
endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;
  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din0, din1, din2;
  logic [3:0] dout0, rise0, fall0, dout1, rise1, fall1, dout2, rise2, fall2;
  logic       any0, any1, any2;

  int errs = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // u0: fast release on ch0; u1: reset level all ones; u2: single-sample filter
  debounce_bank #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2),
                  .MODE(4'b0001), .RESET_VAL(4'b0000)) u0 (
    .CLK(CLK), .rst_n(rst_n), .din(din0), .dout(dout0),
    .rise(rise0), .fall(fall0), .any_change(any0));
  debounce_bank #(.N_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2),
                  .MODE(4'b0000), .RESET_VAL(4'b1111)) u1 (
    .CLK(CLK), .rst_n(rst_n), .din(din1), .dout(dout1),
    .rise(rise1), .fall(fall1), .any_change(any1));
  debounce_bank #(.N_CH(4), .STABLE_CYCLES(1), .SYNC_STAGES(3),
                  .MODE(4'b0101), .RESET_VAL(4'b0011)) u2 (
    .CLK(CLK), .rst_n(rst_n), .din(din2), .dout(dout2),
    .rise(rise2), .fall(fall2), .any_change(any2));

  // Reference model parameters, one entry per instance
  int         ST[3] = '{4, 4, 1};
  int         SY[3] = '{2, 2, 3};
  logic [3:0] MD[3] = '{4'b0001, 4'b0000, 4'b0101};
  logic [3:0] RV[3] = '{4'b0000, 4'b1111, 4'b0011};

  // Model: s at edge k is the din seen at edge k-SY; a new level is taken
  // once ST consecutive samples disagree with the current output.
  logic [3:0] hist [3][1024];
  int         ne;
  logic [3:0] mdout[3], mrise[3], mfall[3];
  int         run[3][4];
  bit         mdl_on = 0;

  task automatic model_reset();
    ne = 0;
    for (int d = 0; d < 3; d++) begin
      mdout[d] = RV[d]; mrise[d] = '0; mfall[d] = '0;
      for (int c = 0; c < 4; c++) run[d][c] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] dv[3];
    logic s, old;
    dv = '{din0, din1, din2};
    for (int d = 0; d < 3; d++) begin
      hist[d][ne] = dv[d];
      mrise[d] = '0; mfall[d] = '0;
      for (int c = 0; c < 4; c++) begin
        s = (ne >= SY[d]) ? hist[d][ne - SY[d]][c] : RV[d][c];
        old = mdout[d][c];
        if (s == old) run[d][c] = 0;
        else if (MD[d][c] && !s) begin mdout[d][c] = 1'b0; run[d][c] = 0; end
        else begin
          run[d][c]++;
          if (run[d][c] >= ST[d]) begin mdout[d][c] = s; run[d][c] = 0; end
        end
        mrise[d][c] = !old && mdout[d][c];
        mfall[d][c] = old && !mdout[d][c];
      end
    end
    if (ne < 1023) ne++;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (mdl_on && rst_n) model_step();
    @(negedge CLK);
  endtask

  task automatic cmp_model();
    chk("u0 dout", dout0, mdout[0]); chk("u0 rise", rise0, mrise[0]);
    chk("u0 fall", fall0, mfall[0]); chk("u0 any", {3'b0, any0}, {3'b0, |(mrise[0] | mfall[0])});
    chk("u1 dout", dout1, mdout[1]); chk("u1 rise", rise1, mrise[1]);
    chk("u1 fall", fall1, mfall[1]); chk("u1 any", {3'b0, any1}, {3'b0, |(mrise[1] | mfall[1])});
    chk("u2 dout", dout2, mdout[2]); chk("u2 rise", rise2, mrise[2]);
    chk("u2 fall", fall2, mfall[2]); chk("u2 any", {3'b0, any2}, {3'b0, |(mrise[2] | mfall[2])});
  endtask

  typedef struct {
    logic [3:0] din;
    int         n;
    logic [3:0] dout, rise, fall;
    logic       any;
  } vec_t;
  vec_t tbl[19];

  initial begin
    // din, cycles to hold, then expected dout/rise/fall/any on u0
    tbl[0]  = '{4'b0001, 5, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0000, 2, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    tbl[5]  = '{4'b0001, 5, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0011, 1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0011, 1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{4'b0011, 1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{4'b0011, 4, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{4'b0011, 1, 4'b0011, 4'b0010, 4'b0000, 1'b1};
    tbl[14] = '{4'b0010, 3, 4'b0010, 4'b0000, 4'b0001, 1'b1};
    tbl[15] = '{4'b0010, 1, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    tbl[16] = '{4'b1011, 5, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    tbl[17] = '{4'b1011, 1, 4'b1011, 4'b1001, 4'b0000, 1'b1};
    tbl[18] = '{4'b1011, 1, 4'b1011, 4'b0000, 4'b0000, 1'b0};

    // Reset with u1 inputs already at its reset level
    din0 = 4'b0000; din1 = 4'b1111; din2 = 4'b0011;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst u0 dout", dout0, 4'b0000);
    chk("rst u0 pulses", rise0 | fall0, 4'b0000);
    chk("rst u1 dout", dout1, 4'b1111);
    chk("rst u2 dout", dout2, 4'b0011);
    chk("rst any", {1'b0, any0, any1, any2}, 4'b0000);
    rst_n = 1'b1;

    for (int t = 0; t < 19; t++) begin
      din0 = tbl[t].din;
      for (int k = 0; k < tbl[t].n; k++) cyc();
      chk($sformatf("vec%0d dout", t), dout0, tbl[t].dout);
      chk($sformatf("vec%0d rise", t), rise0, tbl[t].rise);
      chk($sformatf("vec%0d fall", t), fall0, tbl[t].fall);
      chk($sformatf("vec%0d any", t), {3'b0, any0}, {3'b0, tbl[t].any});
      chk($sformatf("vec%0d u1 hold", t), dout1, 4'b1111);
      chk($sformatf("vec%0d u1 quiet", t), {rise1 | fall1} | {3'b0, any1}, 4'b0000);
    end

    // Reset while ch2 is partway through its count
    din0 = 4'b1111;
    repeat (5) cyc();
    chk("midcnt dout", dout0, 4'b1011);
    rst_n = 1'b0;
    #1;
    chk("async rst dout", dout0, 4'b0000);
    chk("async rst pulses", rise0 | fall0, 4'b0000);
    chk("async rst any", {3'b0, any0}, 4'b0000);
    @(negedge CLK);
    rst_n = 1'b1;
    cyc();
    chk("post rel no pulse", rise0 | fall0, 4'b0000);
    repeat (4) cyc();
    chk("post rel 5 dout", dout0, 4'b0000);
    cyc();
    chk("post rel 6 dout", dout0, 4'b1111);
    chk("post rel 6 rise", rise0, 4'b1111);
    chk("post rel 6 any", {3'b0, any0}, 4'b0001);
    cyc();
    chk("post rel 7 rise", rise0, 4'b0000);

    // Randomized phase against the model, with one reset mid-run
    rst_n = 1'b0;
    din0 = '0; din1 = 4'b1111; din2 = 4'b0011;
    model_reset();
    mdl_on = 1;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int t = 0; t < 600; t++) begin
      logic [3:0] m0, m1, m2;
      for (int b = 0; b < 4; b++) begin
        m0[b] = ($urandom_range(0, 4) == 0);
        m1[b] = ($urandom_range(0, 4) == 0);
        m2[b] = ($urandom_range(0, 2) == 0);
      end
      din0 ^= m0; din1 ^= m1; din2 ^= m2;
      cyc();
      cmp_model();
      if (t == 300) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_model();
        @(negedge CLK);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
